// File: rtl/storage_arbiter_if.sv
// Requester-side bus of the storage arbiter: per-requester req/write/address/data lanes
// and the shared grant/response return path.
interface storage_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         we;
    logic [NUM_REQ-1:0][31:0]   addr;
    logic [NUM_REQ-1:0][31:0]   wdata;
    logic [NUM_REQ-1:0][3:0]    be;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         rvalid;
    logic [31:0]                rdata;
    logic                       err;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/storage_arbiter.sv
// Round-robin arbiter sharing the storage_controller memory port between requesters,
// with SRAM/QSPI region decode, response timeout and a sticky programming-mode halt.
module storage_arbiter #(
    parameter int          NUM_REQ        = 3,
    parameter logic [31:0] EXT_BASE       = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    storage_arbiter_if.slave    bus,
    output logic                busy,
    input  logic                set_programming_mode,
    output logic                mem_access,
    output logic                mem_is_writing,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_d_in,
    output logic [3:0]          mem_be,
    output logic                mem_external,
    input  logic [31:0]         mem_d_out,
    input  logic                mem_out_valid
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, HALT} state_t;

    state_t             state_reg, state_next;
    logic [IW-1:0]      last_grant_reg, idx_reg, sel_idx;
    logic               we_reg, err_reg, halt_resp_reg;
    logic [31:0]        addr_reg, wdata_reg, rdata_reg;
    logic [3:0]         be_reg;
    logic [CW-1:0]      cnt_reg;

    logic [2*NUM_REQ-1:0] req_dbl, rot_req;
    logic [SW-1:0]      start, offset, sum;
    logic               sel_valid, grant_fire, resp_fire, cnt_done;

    // Rotate the request vector so bit 0 is the requester after the last winner.
    assign req_dbl = {bus.req, bus.req};

    always_comb begin
        start     = SW'(last_grant_reg) + SW'(1);
        rot_req   = req_dbl >> start;
        sel_valid = 1'b0;
        offset    = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                sel_valid = 1'b1;
                offset    = SW'(j);
            end
        end
        sum = start + offset;
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        sel_idx = sum[IW-1:0];
    end

    assign grant_fire = rst && (state_reg == IDLE) && !set_programming_mode && sel_valid;
    assign resp_fire  = (state_reg == RESP) || ((state_reg == HALT) && halt_resp_reg);
    assign cnt_done   = (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign bus.gnt[gi]    = grant_fire && (sel_idx == IW'(gi));
            assign bus.rvalid[gi] = resp_fire && (idx_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (set_programming_mode) begin
            state_next = HALT;
        end else begin
            case (state_reg)
                IDLE:    if (sel_valid) state_next = ISSUE;
                ISSUE:   if (mem_out_valid || cnt_done) state_next = RESP;
                RESP:    state_next = IDLE;
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= IW'(NUM_REQ - 1);
            idx_reg        <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            cnt_reg        <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            halt_resp_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            halt_resp_reg <= 1'b0;
            if (grant_fire) begin
                idx_reg        <= sel_idx;
                last_grant_reg <= sel_idx;
                we_reg         <= bus.we[sel_idx];
                addr_reg       <= bus.addr[sel_idx];
                wdata_reg      <= bus.wdata[sel_idx];
                be_reg         <= bus.be[sel_idx];
                cnt_reg        <= '0;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= cnt_reg + CW'(1);
                // Programming mode wins over a coincident out_valid: the access is aborted.
                if (set_programming_mode) begin
                    halt_resp_reg <= 1'b1;
                    rdata_reg     <= '0;
                    err_reg       <= 1'b1;
                end else if (mem_out_valid) begin
                    rdata_reg <= mem_d_out;
                    err_reg   <= 1'b0;
                end else if (cnt_done) begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b1;
                end
            end
        end
    end

    assign bus.rdata      = rdata_reg;
    assign bus.err        = err_reg;
    assign busy           = (state_reg != IDLE);
    assign mem_access     = (state_reg == ISSUE);
    assign mem_is_writing = we_reg;
    assign mem_addr       = addr_reg;
    assign mem_d_in       = wdata_reg;
    assign mem_be         = be_reg;
    assign mem_external   = (addr_reg >= EXT_BASE);
endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: cycle table for SRAM read and round robin,
// hand sequences for external access, timeout, reset and programming mode.
module tb_storage_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, prog, ov;
    logic [N-1:0]      req, we;
    logic [31:0]       addr_v [N];
    logic [31:0]       wdata_v [N];
    logic [3:0]        be_v [N];
    logic [31:0]       dout;

    storage_arbiter_if #(.NUM_REQ(N)) bus_a ();
    storage_arbiter_if #(.NUM_REQ(N)) bus_t ();

    assign bus_a.req = req;
    assign bus_a.we  = we;
    assign bus_t.req = req;
    assign bus_t.we  = we;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_drive
            assign bus_a.addr[gi]  = addr_v[gi];
            assign bus_a.wdata[gi] = wdata_v[gi];
            assign bus_a.be[gi]    = be_v[gi];
            assign bus_t.addr[gi]  = addr_v[gi];
            assign bus_t.wdata[gi] = wdata_v[gi];
            assign bus_t.be[gi]    = be_v[gi];
        end
    endgenerate

    logic        busy_a, macc_a, mwr_a, mext_a;
    logic [31:0] maddr_a, mdin_a;
    logic [3:0]  mbe_a;
    logic        busy_t, macc_t, mwr_t, mext_t;
    logic [31:0] maddr_t, mdin_t;
    logic [3:0]  mbe_t;

    storage_arbiter #(.NUM_REQ(N)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a),
        .set_programming_mode(prog),
        .mem_access(macc_a), .mem_is_writing(mwr_a), .mem_addr(maddr_a),
        .mem_d_in(mdin_a), .mem_be(mbe_a), .mem_external(mext_a),
        .mem_d_out(dout), .mem_out_valid(ov)
    );

    storage_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t), .busy(busy_t),
        .set_programming_mode(prog),
        .mem_access(macc_t), .mem_is_writing(mwr_t), .mem_addr(maddr_t),
        .mem_d_in(mdin_t), .mem_be(mbe_t), .mem_external(mext_t),
        .mem_d_out(dout), .mem_out_valid(ov)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        we;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] dout;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_busy;
        logic        e_macc;
        logic [31:0] e_maddr;
        logic        e_mext;
        logic        e_mwr;
        logic [31:0] e_mdin;
        logic [3:0]  e_mbe;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] rq, input logic w, input logic [31:0] a,
                       input logic v, input logic [31:0] d, input logic [2:0] g, input logic [2:0] rv,
                       input logic [31:0] rd, input logic er, input logic bz, input logic ma,
                       input logic [31:0] mad, input logic mx, input logic mw,
                       input logic [31:0] md, input logic [3:0] mb);
        vec_t e;
        e.rst = r; e.req = rq; e.we = w; e.addr = a; e.ov = v; e.dout = d;
        e.e_gnt = g; e.e_rv = rv; e.e_rdata = rd; e.e_err = er; e.e_busy = bz;
        e.e_macc = ma; e.e_maddr = mad; e.e_mext = mx; e.e_mwr = mw; e.e_mdin = md; e.e_mbe = mb;
        vecs.push_back(e);
    endtask

    // Requester i sits at base + i*0x100; write data and byte enables derive from it.
    task automatic set_addr(input logic [31:0] base);
        for (int i = 0; i < N; i++) begin
            addr_v[i]  = base + 32'(i) * 32'h100;
            wdata_v[i] = addr_v[i] ^ 32'hA5A5_0000;
            be_v[i]    = 4'b0001 << i;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        tick();
        rst = 1'b0; prog = 1'b0; req = '0; we = '0; ov = 1'b0;
        sample();
    endtask

    initial begin
        int          k, n;
        logic [31:0] a, dv;
        logic [2:0]  oh;
        bit          done;

        rst = 1'b0; prog = 1'b0; req = '0; we = '0; ov = 1'b0; dout = '0;
        set_addr(32'h0);

        // Single SRAM read; addr changes after the grant cycle must not leak through.
        add(0, 3'b000, 0, 32'h10,  0, 0,            3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 3'b001, 0, 32'h10,  0, 0,            3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 3'b000, 0, 32'hFF0, 0, 0,            3'b000, 3'b000, 0, 0, 1, 1, 32'h10, 0, 0, 32'hA5A5_0010, 4'h1);
        add(1, 3'b000, 0, 32'hFF0, 1, 32'hCAFE_0001, 3'b000, 3'b000, 0, 0, 1, 1, 32'h10, 0, 0, 32'hA5A5_0010, 4'h1);
        add(1, 3'b000, 0, 32'hFF0, 0, 0,            3'b000, 3'b001, 32'hCAFE_0001, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3'b000, 0, 32'hFF0, 0, 0,            3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3'b000, 0, 32'h0,   0, 0,            3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Round robin with all three requesting writes continuously: 0,1,2,0.
        for (int r = 0; r < 4; r++) begin
            k  = r % 3;
            a  = 32'h20 + 32'(k) * 32'h100;
            oh = 3'b001 << k;
            dv = 32'h11 * 32'(r + 1);
            add(1, 3'b111, 1, 32'h20, 0, 0,  oh,     3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 0);
            add(1, 3'b111, 1, 32'h20, 0, 0,  3'b000, 3'b000, 0,  0, 1, 1, a, 0, 1, a ^ 32'hA5A5_0000, 4'b0001 << k);
            add(1, 3'b111, 1, 32'h20, 1, dv, 3'b000, 3'b000, 0,  0, 1, 1, a, 0, 1, a ^ 32'hA5A5_0000, 4'b0001 << k);
            add(1, 3'b111, 1, 32'h20, 0, 0,  3'b000, oh,     dv, 0, 1, 0, 0, 0, 0, 0, 0);
        end
        add(1, 3'b000, 0, 32'h20, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            tick();
            rst = vecs[i].rst; prog = 1'b0; req = vecs[i].req; we = {N{vecs[i].we}};
            set_addr(vecs[i].addr); ov = vecs[i].ov; dout = vecs[i].dout;
            sample();
            check($sformatf("row%0d gnt", i),        32'(bus_a.gnt),    32'(vecs[i].e_gnt));
            check($sformatf("row%0d rvalid", i),     32'(bus_a.rvalid), 32'(vecs[i].e_rv));
            check($sformatf("row%0d busy", i),       32'(busy_a),       32'(vecs[i].e_busy));
            check($sformatf("row%0d mem_access", i), 32'(macc_a),       32'(vecs[i].e_macc));
            if (vecs[i].e_rv != 3'b000) begin
                check($sformatf("row%0d rdata", i), bus_a.rdata,   vecs[i].e_rdata);
                check($sformatf("row%0d err", i),   32'(bus_a.err), 32'(vecs[i].e_err));
                $display("txn row %0d: rvalid=%b rdata=%h err=%b", i, bus_a.rvalid, bus_a.rdata, bus_a.err);
            end
            if (vecs[i].e_macc) begin
                check($sformatf("row%0d mem_addr", i),       maddr_a,      vecs[i].e_maddr);
                check($sformatf("row%0d mem_external", i),   32'(mext_a),  32'(vecs[i].e_mext));
                check($sformatf("row%0d mem_is_writing", i), 32'(mwr_a),   32'(vecs[i].e_mwr));
                check($sformatf("row%0d mem_d_in", i),       mdin_a,       vecs[i].e_mdin);
                check($sformatf("row%0d mem_be", i),         32'(mbe_a),   32'(vecs[i].e_mbe));
            end
        end

        // External read: out_valid arrives after 20 stalled mem_access cycles.
        reset_cycle();
        tick();
        rst = 1'b1; req = 3'b001; set_addr(32'h0000_2000); dout = 32'h1234_5678;
        sample();
        check("ext gnt", 32'(bus_a.gnt), 32'h1);
        for (int c = 1; c <= 21; c++) begin
            tick();
            req = '0; ov = (c == 21);
            sample();
            check($sformatf("ext c%0d mem_access", c),   32'(macc_a), 32'h1);
            check($sformatf("ext c%0d mem_addr", c),     maddr_a,     32'h0000_2000);
            check($sformatf("ext c%0d mem_external", c), 32'(mext_a), 32'h1);
            check($sformatf("ext c%0d rvalid", c),       32'(bus_a.rvalid), 32'h0);
        end
        tick();
        ov = 1'b0;
        sample();
        check("ext rvalid", 32'(bus_a.rvalid), 32'h1);
        check("ext rdata",  bus_a.rdata,       32'h1234_5678);
        check("ext err",    32'(bus_a.err),    32'h0);
        $display("txn ext: rvalid=%b rdata=%h err=%b", bus_a.rvalid, bus_a.rdata, bus_a.err);

        // Timeout on the 16-cycle instance: address 0x0FFF is never answered.
        reset_cycle();
        tick();
        rst = 1'b1; req = 3'b001; set_addr(32'h0000_0FFF); dout = 32'h5555_AAAA;
        sample();
        check("to gnt", 32'(bus_t.gnt), 32'h1);
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            tick();
            req = '0;
            sample();
            n++;
            if (n == 1) begin
                check("to mem_addr",     maddr_t,     32'h0000_0FFF);
                check("to mem_external", 32'(mext_t), 32'h0);
            end
            if (bus_t.rvalid != '0) done = 1'b1;
        end
        check("to latency", 32'(n), 32'd17);
        check("to rvalid",  32'(bus_t.rvalid), 32'h1);
        check("to err",     32'(bus_t.err),    32'h1);
        check("to rdata",   bus_t.rdata,       32'h0);
        $display("txn timeout: cycles=%0d rvalid=%b rdata=%h err=%b", n, bus_t.rvalid, bus_t.rdata, bus_t.err);
        tick();
        sample();
        check("to busy after", 32'(busy_t), 32'h0);

        // Reset in the middle of ISSUE.
        reset_cycle();
        tick();
        rst = 1'b1; req = 3'b001; set_addr(32'h10);
        sample();
        check("rst gnt", 32'(bus_a.gnt), 32'h1);
        tick();
        req = '0;
        sample();
        check("rst issue mem_access", 32'(macc_a), 32'h1);
        tick();
        rst = 1'b0;
        sample();
        check("rst cycle rvalid", 32'(bus_a.rvalid), 32'h0);
        tick();
        rst = 1'b1;
        sample();
        check("rst after rvalid",     32'(bus_a.rvalid), 32'h0);
        check("rst after busy",       32'(busy_a),       32'h0);
        check("rst after mem_access", 32'(macc_a),       32'h0);
        check("rst after mem_addr",   maddr_a,           32'h0);
        check("rst after rdata",      bus_a.rdata,       32'h0);
        check("rst after err",        32'(bus_a.err),    32'h0);
        tick();
        req = 3'b111;
        sample();
        check("rst regrant idx0", 32'(bus_a.gnt), 32'h1);
        $display("txn reset: regrant gnt=%b", bus_a.gnt);

        // Programming mode arriving in cycle 1 of an SRAM read.
        reset_cycle();
        tick();
        rst = 1'b1; req = 3'b001; set_addr(32'h10); dout = 32'hDEAD_BEEF;
        sample();
        check("pm gnt", 32'(bus_a.gnt), 32'h1);
        tick();
        req = '0; prog = 1'b1;
        sample();
        check("pm c1 mem_access", 32'(macc_a), 32'h1);
        tick();
        ov = 1'b1;
        sample();
        check("pm rvalid",     32'(bus_a.rvalid), 32'h1);
        check("pm err",        32'(bus_a.err),    32'h1);
        check("pm rdata",      bus_a.rdata,       32'h0);
        check("pm mem_access", 32'(macc_a),       32'h0);
        $display("txn prog: rvalid=%b rdata=%h err=%b", bus_a.rvalid, bus_a.rdata, bus_a.err);
        for (int c = 0; c < 6; c++) begin
            tick();
            req = 3'b111; ov = 1'b0; prog = (c < 3);
            sample();
            check($sformatf("pm halt%0d gnt", c),        32'(bus_a.gnt),    32'h0);
            check($sformatf("pm halt%0d mem_access", c), 32'(macc_a),       32'h0);
            check($sformatf("pm halt%0d rvalid", c),     32'(bus_a.rvalid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/storage_arbiter.md
# storage_arbiter

Shares the single storage_controller memory port between NUM_REQ requesters (scalar core instruction fetch, scalar data, vector unit) using round-robin arbitration. Runs a req/gnt/rvalid handshake upstream and drives the controller's memory_access/out_valid protocol downstream. Decodes the SRAM scratchpad versus external QSPI flash region, enforces a response timeout, and blocks all traffic while programming mode is active.

## Interface
- NUM_REQ, 3, number of requesters (2..8); index 0 wins the first arbitration after reset
- EXT_BASE, 32'h0000_1000, addresses >= EXT_BASE go to external QSPI storage
- TIMEOUT_CYCLES, 1024, maximum cycles waited for mem_out_valid before an error response
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req  in  NUM_REQ  per-requester request; held until gnt
- we  in  NUM_REQ  per-requester write enable
- addr  in  NUM_REQ x 32  per-requester byte address
- wdata  in  NUM_REQ x 32  per-requester write data
- be  in  NUM_REQ x 4  per-requester byte enables
- gnt  out  NUM_REQ  one-hot one-cycle grant pulse
- rvalid  out  NUM_REQ  one-hot one-cycle response pulse, to the granted requester
- rdata  out  32  shared response data, valid with rvalid
- err  out  1  response error flag, valid with rvalid
- busy  out  1  transaction in flight (state != IDLE)
- set_programming_mode  in  1  level; forwarded and halts arbitration
- mem_access  out  1  to controller memory_access
- mem_is_writing  out  1  to controller memory_is_writing
- mem_addr  out  32  to controller addr
- mem_d_in  out  32  to controller d_in
- mem_be  out  4  to controller mem_be
- mem_external  out  1  to controller external_storage_access
- mem_d_out  in  32  from controller d_out
- mem_out_valid  in  1  from controller out_valid

## Operation
- States: IDLE, ISSUE, RESP, HALT.
- IDLE: if any req, select the first asserted index searching from (last_grant+1) mod NUM_REQ upward; pulse gnt[i] combinationally; latch we/addr/wdata/be and index i at the clock edge; update last_grant to i; go to ISSUE. last_grant resets to NUM_REQ-1.
- ISSUE: mem_access=1; mem_* driven from the latched registers and held stable throughout. mem_external = (latched addr >= EXT_BASE). Timeout counter increments each cycle.
  - mem_out_valid=1: latch mem_d_out into rdata, err=0, go to RESP. mem_access is low from the next cycle, so the controller's default state does not re-trigger.
  - Counter reaches TIMEOUT_CYCLES-1 with no out_valid: rdata=0, err=1, go to RESP.
- RESP: rvalid[idx]=1 for exactly one cycle; go to IDLE. No grant is issued in RESP.
- HALT: entered from any state while set_programming_mode=1. mem_access=0, gnt=0.
  - An in-flight transaction is answered once, in the first HALT cycle, with rvalid[idx]=1, err=1, rdata=0.
  - Stays in HALT until reset, matching the controller, which never leaves programming mode.
- Writes return rvalid with rdata = mem_d_out as sampled; requesters ignore rdata on writes.
- An address inside neither region (for example, 0x0FFF) is passed through unchanged; the controller never asserts out_valid, so the access ends in a timeout error.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, err=0, busy=0, all mem_* outputs 0, state IDLE, counter 0.
- SRAM access: gnt in cycle 0, mem_access in cycles 1–2, mem_out_valid in cycle 2, rvalid in cycle 3. Throughput is one SRAM transaction per 4 cycles.
- External access: gnt in cycle 0, mem_access from cycle 1 until the out_valid cycle (controller external_done), rvalid one cycle after that.
- Timeout: err rvalid exactly TIMEOUT_CYCLES+1 cycles after gnt.
- A request arriving while busy waits. Requests held continuously by every requester are granted in rotation 0,1,2,0,...
- The req/addr a requester presents in the gnt cycle are the values captured. A requester may change them from the next cycle.
- Reset mid-transaction returns to IDLE with reset values next cycle; no rvalid is issued.

## Test plan
- Single SRAM read: req[0], addr=0x10, we=0 -> gnt[0] in cycle 0, mem_access=1 with mem_addr=0x10 and mem_external=0 in cycles 1–2, rvalid[0] in cycle 3 with rdata equal to the mem_d_out value at out_valid, err=0.
- Round robin: req=3'b111 held continuously -> grants in order 0,1,2,0, each 4 cycles apart; no requester is granted twice before the others are served.
- External read: addr=0x0000_2000, out_valid returned 20 cycles after mem_access -> mem_external=1, mem_addr held stable for all 20 cycles, rvalid 1 cycle after out_valid.
- Timeout: TIMEOUT_CYCLES=16, out_valid never asserted -> rvalid with err=1 and rdata=0 exactly 17 cycles after gnt; busy returns to 0.
- Programming mode mid-transaction: set_programming_mode in cycle 1 of an SRAM read -> one rvalid with err=1, then mem_access=0 and gnt=0 permanently, even with req=3'b111.
- Reset mid-ISSUE: rst=0 for one cycle -> all outputs at reset values, no rvalid, and the next request is granted to index 0.
